// File: rtl/sirv_qspi_flashxip.sv
// XIP flash read sequencer: turns one word read into cmd/addr/pad/data
// link frames for the QSPI media stage and returns the assembled word.
module sirv_qspi_flashxip #(
  parameter int AW   = 24,
  parameter int PADW = 4
) (
  input  logic          clock,
  input  logic          rst_n,
  input  logic          io_en,
  input  logic          io_req_valid,
  output logic          io_req_ready,
  input  logic [AW-1:0] io_req_addr,
  output logic          io_resp_valid,
  input  logic          io_resp_ready,
  output logic [31:0]   io_resp_data,
  input  logic          io_ctrl_cmd_en,
  input  logic [7:0]    io_ctrl_cmd_code,
  input  logic [1:0]    io_ctrl_cmd_proto,
  input  logic [1:0]    io_ctrl_addr_proto,
  input  logic [PADW-1:0] io_ctrl_pad_cnt,
  input  logic [1:0]    io_ctrl_data_proto,
  input  logic          io_link_tx_ready,
  output logic          io_link_tx_valid,
  output logic [7:0]    io_link_tx_bits,
  output logic [7:0]    io_link_cnt,
  output logic [1:0]    io_link_fmt_proto,
  output logic          io_link_fmt_endian,
  output logic          io_link_fmt_iodir,
  output logic          io_link_cs_set,
  output logic          io_link_cs_clear,
  output logic          io_link_cs_hold,
  input  logic          io_link_rx_valid,
  input  logic [7:0]    io_link_rx_bits,
  input  logic          io_link_active,
  output logic          io_busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_PAD,
    S_DATA, S_DRAIN, S_CSCLR, S_RESP
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            cmd_en_q, cmd_en_d;
  logic [7:0]      cmd_code_q, cmd_code_d;
  logic [1:0]      cmd_proto_q, cmd_proto_d;
  logic [1:0]      addr_proto_q, addr_proto_d;
  logic [PADW-1:0] pad_cnt_q, pad_cnt_d;
  logic [1:0]      data_proto_q, data_proto_d;
  logic [1:0]      fcnt_q, fcnt_d;
  logic [3:0]      rx_cnt_q, rx_cnt_d;
  logic [31:0]     data_q, data_d;

  logic       hs, in_txn, rx_inc, data_st;
  logic [3:0] total, base, ridx, rx_next;

  assign in_txn = (state_q == S_CMD) | (state_q == S_ADDR)
                | (state_q == S_PAD) | (state_q == S_DATA)
                | (state_q == S_DRAIN);
  assign data_st = (state_q == S_DATA) | (state_q == S_DRAIN);

  assign io_req_ready = rst_n & (state_q == S_IDLE)
                      & io_en & ~io_link_active;
  assign io_resp_valid      = (state_q == S_RESP);
  assign io_resp_data       = data_q;
  assign io_link_cs_set     = in_txn;
  assign io_link_cs_hold    = in_txn;
  assign io_link_cs_clear   = (state_q == S_CSCLR);
  assign io_link_fmt_endian = 1'b0;
  assign io_busy            = (state_q != S_IDLE);

  assign hs      = io_link_tx_valid & io_link_tx_ready;
  assign total   = 4'd7 + {3'b0, cmd_en_q} + {3'b0, |pad_cnt_q};
  assign base    = total - 4'd4;
  assign rx_inc  = io_link_rx_valid & in_txn;
  assign rx_next = rx_cnt_q + {3'b0, rx_inc};
  // Wraps high for pre-data indices, so ridx < 4 marks data bytes only.
  assign ridx    = rx_cnt_q - base;

  always_comb begin
    io_link_tx_valid  = 1'b0;
    io_link_tx_bits   = 8'h00;
    io_link_cnt       = 8'h00;
    io_link_fmt_proto = 2'b00;
    io_link_fmt_iodir = 1'b0;
    unique case (state_q)
      S_CMD: begin
        io_link_tx_valid  = 1'b1;
        io_link_tx_bits   = cmd_code_q;
        io_link_cnt       = 8'd8;
        io_link_fmt_proto = cmd_proto_q;
        io_link_fmt_iodir = 1'b1;
      end
      S_ADDR: begin
        io_link_tx_valid  = 1'b1;
        io_link_cnt       = 8'd8;
        io_link_fmt_proto = addr_proto_q;
        io_link_fmt_iodir = 1'b1;
        unique case (fcnt_q)
          2'd0:    io_link_tx_bits = addr_q[AW-1 -: 8];
          2'd1:    io_link_tx_bits = addr_q[AW-9 -: 8];
          default: io_link_tx_bits = addr_q[AW-17 -: 8];
        endcase
      end
      S_PAD: begin
        io_link_tx_valid  = 1'b1;
        io_link_cnt       = {{(8-PADW){1'b0}}, pad_cnt_q};
        io_link_fmt_proto = data_proto_q;
      end
      S_DATA: begin
        io_link_tx_valid  = 1'b1;
        io_link_cnt       = 8'd8;
        io_link_fmt_proto = data_proto_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    cmd_en_d     = cmd_en_q;
    cmd_code_d   = cmd_code_q;
    cmd_proto_d  = cmd_proto_q;
    addr_proto_d = addr_proto_q;
    pad_cnt_d    = pad_cnt_q;
    data_proto_d = data_proto_q;
    fcnt_d       = fcnt_q;
    rx_cnt_d     = rx_next;
    data_d       = data_q;
    if (rx_inc && data_st && ridx[3:2] == 2'b00)
      data_d[{ridx[1:0], 3'b000} +: 8] = io_link_rx_bits;
    unique case (state_q)
      S_IDLE: begin
        if (io_req_valid && io_req_ready) begin
          addr_d       = io_req_addr;
          cmd_en_d     = io_ctrl_cmd_en;
          cmd_code_d   = io_ctrl_cmd_code;
          cmd_proto_d  = io_ctrl_cmd_proto;
          addr_proto_d = io_ctrl_addr_proto;
          pad_cnt_d    = io_ctrl_pad_cnt;
          data_proto_d = io_ctrl_data_proto;
          fcnt_d       = 2'd0;
          rx_cnt_d     = 4'd0;
          state_d      = io_ctrl_cmd_en ? S_CMD : S_ADDR;
        end
      end
      S_CMD: if (hs) state_d = S_ADDR;
      S_ADDR: begin
        if (hs) begin
          fcnt_d = fcnt_q + 2'd1;
          if (fcnt_q == 2'd2) begin
            fcnt_d  = 2'd0;
            state_d = (pad_cnt_q != '0) ? S_PAD : S_DATA;
          end
        end
      end
      S_PAD: if (hs) state_d = S_DATA;
      S_DATA: begin
        if (hs) begin
          fcnt_d = fcnt_q + 2'd1;
          if (fcnt_q == 2'd3) begin
            fcnt_d  = 2'd0;
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: if (rx_next == total) state_d = S_CSCLR;
      S_CSCLR: state_d = S_RESP;
      S_RESP:  if (io_resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      cmd_en_q     <= 1'b0;
      cmd_code_q   <= 8'h00;
      cmd_proto_q  <= 2'b00;
      addr_proto_q <= 2'b00;
      pad_cnt_q    <= '0;
      data_proto_q <= 2'b00;
      fcnt_q       <= 2'd0;
      rx_cnt_q     <= 4'd0;
      data_q       <= 32'h0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      cmd_en_q     <= cmd_en_d;
      cmd_code_q   <= cmd_code_d;
      cmd_proto_q  <= cmd_proto_d;
      addr_proto_q <= addr_proto_d;
      pad_cnt_q    <= pad_cnt_d;
      data_proto_q <= data_proto_d;
      fcnt_q       <= fcnt_d;
      rx_cnt_q     <= rx_cnt_d;
      data_q       <= data_d;
    end
  end

endmodule

// File: tb/tb_sirv_qspi_flashxip.sv
// Directed bench for sirv_qspi_flashxip with a cycle-level media model.
module tb_sirv_qspi_flashxip;

  logic        clock = 1'b0;
  logic        rst_n;
  logic        io_en, io_req_valid, io_req_ready;
  logic [23:0] io_req_addr;
  logic        io_resp_valid, io_resp_ready;
  logic [31:0] io_resp_data;
  logic        io_ctrl_cmd_en;
  logic [7:0]  io_ctrl_cmd_code;
  logic [1:0]  io_ctrl_cmd_proto, io_ctrl_addr_proto, io_ctrl_data_proto;
  logic [3:0]  io_ctrl_pad_cnt;
  logic        io_link_tx_ready, io_link_tx_valid;
  logic [7:0]  io_link_tx_bits, io_link_cnt;
  logic [1:0]  io_link_fmt_proto;
  logic        io_link_fmt_endian, io_link_fmt_iodir;
  logic        io_link_cs_set, io_link_cs_clear, io_link_cs_hold;
  logic        io_link_rx_valid;
  logic [7:0]  io_link_rx_bits;
  logic        io_link_active, io_busy;

  sirv_qspi_flashxip dut (
    .clock(clock), .rst_n(rst_n), .io_en(io_en),
    .io_req_valid(io_req_valid), .io_req_ready(io_req_ready),
    .io_req_addr(io_req_addr),
    .io_resp_valid(io_resp_valid), .io_resp_ready(io_resp_ready),
    .io_resp_data(io_resp_data),
    .io_ctrl_cmd_en(io_ctrl_cmd_en), .io_ctrl_cmd_code(io_ctrl_cmd_code),
    .io_ctrl_cmd_proto(io_ctrl_cmd_proto),
    .io_ctrl_addr_proto(io_ctrl_addr_proto),
    .io_ctrl_pad_cnt(io_ctrl_pad_cnt),
    .io_ctrl_data_proto(io_ctrl_data_proto),
    .io_link_tx_ready(io_link_tx_ready), .io_link_tx_valid(io_link_tx_valid),
    .io_link_tx_bits(io_link_tx_bits), .io_link_cnt(io_link_cnt),
    .io_link_fmt_proto(io_link_fmt_proto),
    .io_link_fmt_endian(io_link_fmt_endian),
    .io_link_fmt_iodir(io_link_fmt_iodir),
    .io_link_cs_set(io_link_cs_set), .io_link_cs_clear(io_link_cs_clear),
    .io_link_cs_hold(io_link_cs_hold),
    .io_link_rx_valid(io_link_rx_valid), .io_link_rx_bits(io_link_rx_bits),
    .io_link_active(io_link_active), .io_busy(io_busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        cmd_en;
    logic [7:0]  cmd;
    logic [1:0]  cp, ap, dp;
    logic [3:0]  pad;
    logic [23:0] addr;
    logic [71:0] rx;
    logic [31:0] exp;
    int          frames;
    int          stall_at;
    bit          drop_en;
    bit          resp_stall;
  } vec_t;

  int n_chk = 0;
  int n_pass = 0;

  logic [7:0] fr_bits [16];
  logic [7:0] fr_cnt  [16];
  logic [1:0] fr_prot [16];
  logic       fr_dir  [16];
  logic [2:0] fr_cs   [16];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [63:0] all_outs();
    return {5'b0, io_req_ready, io_resp_valid, io_resp_data,
            io_link_tx_valid, io_link_tx_bits, io_link_cnt,
            io_link_fmt_proto, io_link_fmt_endian, io_link_fmt_iodir,
            io_link_cs_set, io_link_cs_clear, io_link_cs_hold, io_busy};
  endfunction

  task automatic run_vec(input int id, input vec_t v);
    logic [7:0] eb [16];
    logic [7:0] ec [16];
    logic [1:0] ep [16];
    logic       ed [16];
    int m = 0, n = 0, stall = 0, rstall = 0, csclr = 0;
    bit pend = 0, acc_prev = 0, done = 0, stall_used = 0;
    logic [7:0] pbits = 8'h00, sb = 8'h00, sc = 8'h00;
    logic [31:0] held = 32'h0;
    if (v.cmd_en) begin
      eb[m] = v.cmd; ec[m] = 8'd8; ep[m] = v.cp; ed[m] = 1'b1; m++;
    end
    for (int i = 0; i < 3; i++) begin
      eb[m] = v.addr[23-8*i -: 8]; ec[m] = 8'd8;
      ep[m] = v.ap; ed[m] = 1'b1; m++;
    end
    if (v.pad != 4'd0) begin
      eb[m] = 8'h00; ec[m] = {4'b0, v.pad}; ep[m] = v.dp; ed[m] = 1'b0; m++;
    end
    for (int i = 0; i < 4; i++) begin
      eb[m] = 8'h00; ec[m] = 8'd8; ep[m] = v.dp; ed[m] = 1'b0; m++;
    end
    @(negedge clock);
    io_en = 1'b1;
    io_req_valid = 1'b1;
    io_req_addr = v.addr;
    io_ctrl_cmd_en = v.cmd_en;
    io_ctrl_cmd_code = v.cmd;
    io_ctrl_cmd_proto = v.cp;
    io_ctrl_addr_proto = v.ap;
    io_ctrl_pad_cnt = v.pad;
    io_ctrl_data_proto = v.dp;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      io_link_rx_valid = pend;
      io_link_rx_bits = pbits;
      pend = 0;
      if (acc_prev) begin
        io_req_valid = 1'b0;
        io_req_addr = ~v.addr;
        io_ctrl_cmd_en = ~v.cmd_en;
        io_ctrl_cmd_code = ~v.cmd;
        io_ctrl_cmd_proto = ~v.cp;
        io_ctrl_addr_proto = ~v.ap;
        io_ctrl_pad_cnt = ~v.pad;
        io_ctrl_data_proto = ~v.dp;
        if (v.drop_en) io_en = 1'b0;
        acc_prev = 0;
      end
      if (io_req_valid && io_req_ready) acc_prev = 1;
      io_link_tx_ready = 1'b0;
      if (io_link_tx_valid) begin
        if (n == v.stall_at && !stall_used) begin
          stall_used = 1; stall = 4;
          sb = io_link_tx_bits; sc = io_link_cnt;
        end
        if (stall > 0) begin
          if (stall < 4)
            check($sformatf("v%0d stall_hold", id),
                  {io_link_tx_bits, io_link_cnt}, {sb, sc});
          stall--;
        end else begin
          io_link_tx_ready = 1'b1;
          if (n < 16) begin
            fr_bits[n] = io_link_tx_bits;
            fr_cnt[n]  = io_link_cnt;
            fr_prot[n] = io_link_fmt_proto;
            fr_dir[n]  = io_link_fmt_iodir;
            fr_cs[n]   = {io_link_cs_set, io_link_cs_hold,
                          io_link_fmt_endian};
          end
          pend = 1;
          pbits = (n < 9) ? v.rx[8*n +: 8] : 8'h00;
          n++;
        end
      end
      if (io_link_cs_clear) csclr++;
      io_resp_ready = 1'b0;
      if (io_resp_valid) begin
        if (rstall == 0) held = io_resp_data;
        if (v.resp_stall && rstall < 5) begin
          if (rstall > 0) begin
            check($sformatf("v%0d resp_hold", id),
                  {io_resp_valid, io_resp_data}, {1'b1, held});
            check($sformatf("v%0d req_ready_in_resp", id),
                  io_req_ready, 0);
          end
          rstall++;
        end else begin
          io_resp_ready = 1'b1;
          check($sformatf("v%0d cs_clear_before_resp", id), csclr, 1);
          check($sformatf("v%0d resp_data", id), io_resp_data, v.exp);
          done = 1;
        end
      end
      @(negedge clock);
    end
    io_resp_ready = 1'b0;
    io_link_rx_valid = 1'b0;
    io_link_tx_ready = 1'b0;
    io_en = 1'b1;
    check($sformatf("v%0d completed", id), done, 1);
    check($sformatf("v%0d idle_after", id),
          {io_resp_valid, io_busy}, 2'b00);
    check($sformatf("v%0d frame_count", id), n, v.frames);
    check($sformatf("v%0d model_count", id), n, m);
    for (int i = 0; i < n && i < m && i < 16; i++)
      check($sformatf("v%0d frame%0d", id, i),
            {fr_bits[i], fr_cnt[i], fr_prot[i], fr_dir[i], fr_cs[i]},
            {eb[i], ec[i], ep[i], ed[i], 3'b110});
  endtask

  vec_t vt [5];
  bit hit;

  initial begin
    vt[0] = '{1'b1, 8'h03, 2'd0, 2'd0, 2'd0, 4'd0, 24'h123456,
              72'h00_44_33_22_11_EE_EE_EE_EE, 32'h44332211,
              8, -1, 1'b0, 1'b0};
    vt[1] = '{1'b1, 8'h0B, 2'd0, 2'd0, 2'd2, 4'd8, 24'h000100,
              72'hDD_CC_BB_AA_EE_EE_EE_EE_EE, 32'hDDCCBBAA,
              9, -1, 1'b0, 1'b0};
    vt[2] = '{1'b0, 8'h5A, 2'd0, 2'd0, 2'd0, 4'd0, 24'hABCDEF,
              72'h00_00_78_56_34_12_EE_EE_EE, 32'h78563412,
              7, -1, 1'b1, 1'b0};
    vt[3] = '{1'b1, 8'h03, 2'd1, 2'd1, 2'd1, 4'd3, 24'h00FF80,
              72'h01_02_03_04_EE_EE_EE_EE_EE, 32'h01020304,
              9, 2, 1'b0, 1'b0};
    vt[4] = '{1'b1, 8'h6B, 2'd2, 2'd2, 2'd2, 4'd2, 24'hFFFFFF,
              72'hF0_E1_D2_C3_EE_EE_EE_EE_EE, 32'hF0E1D2C3,
              9, -1, 1'b0, 1'b1};

    rst_n = 1'b0;
    io_en = 1'b1;
    io_req_valid = 1'b0;
    io_req_addr = 24'h0;
    io_resp_ready = 1'b0;
    io_ctrl_cmd_en = 1'b0;
    io_ctrl_cmd_code = 8'h00;
    io_ctrl_cmd_proto = 2'd0;
    io_ctrl_addr_proto = 2'd0;
    io_ctrl_pad_cnt = 4'd0;
    io_ctrl_data_proto = 2'd0;
    io_link_tx_ready = 1'b0;
    io_link_rx_valid = 1'b0;
    io_link_rx_bits = 8'h00;
    io_link_active = 1'b0;
    #1;
    check("reset_outputs", all_outs(), 64'h0);
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
    #1;
    check("ready_after_reset", io_req_ready, 1);

    for (int i = 0; i < 5; i++) run_vec(i, vt[i]);

    io_link_active = 1'b1;
    io_req_valid = 1'b1;
    io_req_addr = 24'h000010;
    io_ctrl_cmd_en = 1'b1;
    io_ctrl_cmd_code = 8'h03;
    io_ctrl_pad_cnt = 4'd0;
    #1;
    check("req_blocked_active", io_req_ready, 0);
    @(negedge clock);
    check("req_blocked_active2", {io_req_ready, io_busy}, 2'b00);
    io_link_active = 1'b0;
    #1;
    check("req_ready_active_low", io_req_ready, 1);
    @(negedge clock);
    io_req_valid = 1'b0;
    check("accepted_busy", io_busy, 1);
    io_link_tx_ready = 1'b1;
    hit = 0;
    for (int c = 0; c < 20 && !hit; c++) begin
      @(negedge clock);
      if (io_link_tx_valid && !io_link_fmt_iodir) hit = 1;
    end
    check("reached_data", hit, 1);
    io_req_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    check("reset_mid_data", all_outs(), 64'h0);
    @(negedge clock);
    io_link_active = 1'b1;
    rst_n = 1'b1;
    #1;
    check("post_reset_active", io_req_ready, 0);
    @(negedge clock);
    io_req_valid = 1'b0;
    io_link_active = 1'b0;
    #1;
    check("post_reset_ready", {io_req_ready, io_busy}, 2'b10);
    hit = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      if (io_resp_valid || io_busy) hit = 1;
    end
    check("no_resp_after_reset", hit, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sirv_qspi_flashxip.md
Name: sirv_qspi_flashxip

Overview:
Memory-mapped (XIP) flash read sequencer that sits directly upstream of the QSPI media stage and drives its io_link_* interface. It accepts one 32-bit read request at a time and issues, as a series of link frames, an optional command byte, 3 address bytes and optional dummy cycles. It then reads 4 data bytes, assembles them into a word and returns the word on a response handshake. At the end of each transaction it releases chip select.

Parameters:
AW, 24, request address width (fixed to 3 address bytes)
PADW, 4, width of the dummy-cycle count field

Ports:
clock  in  1  single clock domain
rst_n  in  1  asynchronous, active-low reset
io_en  in  1  XIP enable; gates new request acceptance only
io_req_valid  in  1  read request valid
io_req_ready  out  1  request accepted when valid&ready
io_req_addr  in  24  flash byte address
io_resp_valid  out  1  read data valid
io_resp_ready  in  1  consumer accepts data
io_resp_data  out  32  assembled word
io_ctrl_cmd_en  in  1  send command byte
io_ctrl_cmd_code  in  8  command opcode
io_ctrl_cmd_proto  in  2  lane mode for command frame
io_ctrl_addr_proto  in  2  lane mode for address frames
io_ctrl_pad_cnt  in  4  dummy bit-times; 0 means no pad frame
io_ctrl_data_proto  in  2  lane mode for pad and data frames
io_link_tx_ready  in  1  media accepts frame
io_link_tx_valid  out  1  frame valid
io_link_tx_bits  out  8  frame transmit data
io_link_cnt  out  8  bit-times in frame
io_link_fmt_proto  out  2  frame lane mode
io_link_fmt_endian  out  1  always 0 (MSB first)
io_link_fmt_iodir  out  1  1 = transmit, 0 = receive
io_link_cs_set  out  1  request CS assertion
io_link_cs_clear  out  1  release CS pulse
io_link_cs_hold  out  1  keep CS between frames
io_link_rx_valid  in  1  one pulse per completed frame
io_link_rx_bits  in  8  received byte
io_link_active  in  1  media holds CS asserted
io_busy  out  1  state != IDLE

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; all counters = 0.
  - Outputs 0: io_req_ready, io_resp_valid, io_resp_data, io_link_tx_valid, io_link_tx_bits, io_link_cnt, all fmt fields, cs_set, cs_clear, cs_hold, io_busy.
  - Reset in mid-transaction abandons the transaction and emits no response.
- io_req_ready = (state==IDLE) & io_en & !io_link_active.
  - On acceptance the block latches io_req_addr and all io_ctrl_* fields.
  - Control inputs that change during a transaction have no effect on it.
- States: IDLE -> CMD -> ADDR -> PAD -> DATA -> DRAIN -> CSCLR -> RESP -> IDLE.
  - CMD is skipped when cmd_en=0.
  - PAD is skipped when pad_cnt=0.
- Frame sequence. Each frame is held stable while tx_valid & !tx_ready.
  - CMD: tx_bits=cmd_code, cnt=8, iodir=1, proto=cmd_proto.
  - ADDR: 3 frames, address bytes [23:16], [15:8], [7:0]; cnt=8, iodir=1, proto=addr_proto.
  - PAD: 1 frame, tx_bits=0, cnt=pad_cnt (zero-extended), iodir=0, proto=data_proto.
  - DATA: 4 frames, tx_bits=0, cnt=8, iodir=0, proto=data_proto.
- A state advances to the next frame on the cycle where tx_valid & tx_ready. tx_valid may stay high back-to-back with no bubble.
- cs_set=1 and cs_hold=1 from CMD through DRAIN; both are 0 in all other states.
- rx counting:
  - rx_cnt increments on every io_link_rx_valid, including in the same cycle as a tx handshake.
  - Total frames = cmd_en + 3 + (pad_cnt!=0) + 4.
  - Frames whose rx index is below (total-4) are discarded.
  - Data rx pulse k (k = 0..3) writes rx_bits into resp_data[8k+7:8k], i.e. the byte at addr+k.
- DATA -> DRAIN after the 4th data frame handshake. DRAIN -> CSCLR when rx_cnt == total; this may fall in the same cycle as the final rx pulse.
- CSCLR: io_link_cs_clear=1 for exactly one cycle, then RESP.
- RESP: io_resp_valid=1 and io_resp_data held stable until io_resp_ready, then IDLE. io_resp_valid is 0 in all other states.
- Excess rx pulses outside DATA/DRAIN are ignored.
- io_en deasserted mid-transaction: the transaction completes normally.

Test Plan:
- cmd_en=1, cmd 0x03, protos 0, pad 0, addr 0x123456, media model returns data bytes 11,22,33,44 -> tx_bits sequence 03,12,34,56,00x4 with iodir 1,1,1,1,0,0,0,0 and cnt=8; resp_data=0x44332211; one cs_clear pulse before resp_valid.
- cmd 0x0B, pad_cnt=8, data_proto=2 -> 9 frames; frame 5 has cnt=8, iodir=0, proto=2; data frames have proto=2; total rx pulses counted = 9.
- cmd_en=0, addr 0xABCDEF -> first frame tx_bits=0xAB with cs_set=1; 7 frames total.
- tx_ready held low 4 cycles during ADDR -> tx_valid, tx_bits and cnt stable; no frame skipped or duplicated.
- resp_ready low 5 cycles -> resp_valid stays 1, data stable, req_ready 0; the new request is accepted only after the RESP handshake and once io_link_active=0.
- rst_n pulsed low during DATA -> all outputs 0 immediately; after release, req_ready=1 once io_link_active=0 and io_en=1.
